// File: rtl/memory_access.sv
// memory_access: RV32I MEM stage with dmem handshake, load alignment and MEM/WB register.
// Define MA_PERF_CNT_EN to add the stall-cycle and memory-op performance counters.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;
endpackage

module memory_access
  import rv32i_types::*;
`ifdef MA_PERF_CNT_EN
  #(parameter int PERF_CNT_W = 32)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic [1:0]        addr_offset_in,
  input  logic              IF_stall,
  output logic              data_read,
  output logic              data_write,
  output logic [3:0]        data_mbe,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  input  logic [31:0]       data_rdata,
  input  logic              data_resp,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out,
  output logic [31:0]       rdata_out,
  output logic              br_en_out,
  output logic [31:0]       mem_wb_data
`ifdef MA_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_mem_ops
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] cap_q, cap_d, shifted, aligned, ld_data;
  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op, adv;
  always_comb begin
    is_load    = ctrl_word_in.opcode == op_load;
    is_store   = ctrl_word_in.opcode == op_store;
    mem_op     = is_load || is_store;
    funct3     = instruction_in[14:12];
    MA_stall   = !rst && mem_op && !(data_resp || state_q == DONE);
    adv        = !MA_stall && !IF_stall;
    data_read  = !rst && is_load && state_q != DONE;
    data_write = !rst && is_store && state_q != DONE;
    data_mbe   = (rst || !mem_op) ? 4'h0 : mem_byte_enable_in;
    data_addr  = {alu_in[31:2], 2'b00};
    data_wdata = rs2_in << {addr_offset_in, 3'b000};
    shifted    = data_rdata >> {addr_offset_in, 3'b000};
    aligned    = funct3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                 funct3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                 funct3 == 3'b100 ? {24'h0, shifted[7:0]} :
                 funct3 == 3'b101 ? {16'h0, shifted[15:0]} : data_rdata;
    ld_data    = state_q == DONE ? cap_q : aligned;
    cap_d      = (mem_op && data_resp && state_q != DONE) ? aligned : cap_q;
    state_d    = state_q == DONE ? (adv ? IDLE : DONE) :
                 !mem_op         ? IDLE :
                 data_resp       ? (IF_stall ? DONE : IDLE) : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cap_q           <= '0;
      ctrl_word_out   <= '0;
      instruction_out <= '0;
      PC_out          <= '0;
      alu_out         <= '0;
      rdata_out       <= '0;
      br_en_out       <= 1'b0;
      mem_wb_data     <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      if (adv) begin
        ctrl_word_out   <= ctrl_word_in;
        instruction_out <= instruction_in;
        PC_out          <= PC_in;
        alu_out         <= alu_in;
        rdata_out       <= is_load ? ld_data : 32'h0;
        br_en_out       <= br_en_in;
        mem_wb_data     <= is_load ? ld_data : alu_in;
      end
    end
  end
`ifdef MA_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_mem_ops      <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + PERF_CNT_W'(MA_stall);
      perf_mem_ops      <= perf_mem_ops + PERF_CNT_W'(data_resp);
    end
  end
`endif
endmodule
